mem_stage_pipe: RTL
===================

Name: mem_stage_pipe

Overview:
Parametrised successor to the single-cycle memory stage. It is a registered EX/MEM-to-WB stage that drives a latency-tolerant data-memory port with a req/gnt/rvalid handshake. It supports byte, half, word and dword transfers with little-endian lane steering and sign/zero extension. It raises a stall toward EX while an access is in flight and sits between execute_stage and writeback_stage in the 5-stage ARM64 pipeline.

Parameters:
DATA_W, 64, data path width in bits; power of two, at least 16
ADDR_W, 64, address width
RD_W, 5, destination register index width
LANES, DATA_W/8, derived byte-lane count; not overridable

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ex_valid  in  1  EX holds a valid instruction
ex_alu_result  in  ADDR_W  address, or ALU result passed through
ex_reg_data2  in  DATA_W  store data, right-aligned
ex_bl_write_data  in  DATA_W  link value for BL
ex_rd  in  RD_W  destination register
ex_control  in  6  {RegWrite, MemWrite, MemRead, MemToReg, SetFlags, BL}
ex_size  in  2  00=byte, 01=half, 10=word, 11=dword
ex_signed  in  1  sign-extend the load result
ex_flags  in  4  NZCV
mem_stall  out  1  EX must hold its outputs
dmem_req  out  1  memory request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  ADDR_W  doubleword-aligned address (low 3 bits zero)
dmem_be  out  LANES  byte enables
dmem_wdata  out  DATA_W  lane-steered store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  DATA_W  load data
wb_valid  out  1  WB registers hold a new instruction, one-cycle pulse
wb_mem_data  out  DATA_W  extended load data
wb_alu_result  out  ADDR_W
wb_bl_write_data  out  DATA_W
wb_rd  out  RD_W
wb_control  out  4  {RegWrite, MemToReg, SetFlags, BL}
wb_flags  out  4
wb_fault  out  1  misalignment fault; tied 0 without the macro

Behaviour:
- Reset (async, reset_n=0): state=IDLE; every wb_* output, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata = 0; mem_stall=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, ex_valid=0: wb_valid=0 and wb_control=0 on the next edge; all other wb_* hold.
- IDLE, ex_valid=1, no MemRead/MemWrite: all fields are registered to wb_* next edge with wb_valid=1. Latency is 1 cycle, no stall.
- IDLE, ex_valid=1, memory op: latch all EX fields, go to REQ. mem_stall=1 in every cycle where state is not IDLE.
- Both MemWrite and MemRead set: the store wins; MemRead is ignored.
- REQ: dmem_req=1. addr, we, be and wdata stay stable until dmem_gnt.
  - Store with gnt: WB registers load (wb_valid=1, wb_mem_data=0), go to IDLE.
  - Load with gnt: go to WAIT; dmem_req drops the same edge.
- WAIT: dmem_req=0. On dmem_rvalid, the extracted data goes to wb_mem_data with wb_valid=1; go to IDLE.
- Minimum latency: store 2 cycles, load 3 cycles. Zero-wait gnt and rvalid must work, including rvalid in the cycle right after gnt.
- Lanes: off=addr[2:0].
  - dmem_be = ((1<<bytes)-1)<<off, truncated to LANES bits.
  - dmem_wdata = ex_reg_data2<<(8*off).
  - Load = (dmem_rdata>>(8*off)) masked to the size, then sign-extended if ex_signed, else zero-extended.
- dmem_gnt outside REQ and dmem_rvalid outside WAIT are ignored.
- Reset asserted mid-access: the access is abandoned. A late rvalid after reset is ignored because the block is in IDLE.
- mem_stall deasserts in the cycle after the completing edge. EX may present the next instruction that cycle.

Optional Feature:
MEM_STAGE_ALIGN_CHECK_EN.
- Defined: an access with addr not a multiple of the size is never issued to memory. It completes in 1 cycle with wb_fault=1 and wb_control RegWrite forced to 0. wb_fault clears on the next wb_valid.
- Undefined: wb_fault is tied to 0. Misaligned accesses are issued, and lanes beyond the doubleword are dropped through truncated be and shifted data.

Decomposition:
- Package mem_stage_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - state enum
  - ex_control bit-index constants (CTL_REGWRITE, CTL_MEMWRITE, ...)
  - function size_bytes()
- Sub-module mem_lane_align: combinational be and wdata generation plus load extract/extend, parametrised by DATA_W.

Test Plan:
- ALU op, ex_alu_result=0x1234, RegWrite=1, no mem -> wb_valid the next cycle, wb_alu_result=0x1234, mem_stall never 1.
- STURB, addr=0x1003, data=0xAB, gnt after 2 wait cycles -> dmem_addr=0x1000, be=0x08, wdata=0xAB000000, req held 3 cycles, wb_valid on the gnt+1 edge.
- LDURSH, addr=0x2002, rdata=0x00000000_80010000, zero-wait gnt and rvalid -> wb_mem_data=0xFFFFFFFF_FFFF8001 after 3 cycles; with ex_signed=0 -> 0x8001.
- Reset pulse while in WAIT, then rvalid=1 -> state IDLE, wb_valid stays 0, mem_stall=0.
- Back-to-back LDUR then ADD -> ADD held by mem_stall, accepted the cycle after load completion, two wb_valid pulses in order.
- With MEM_STAGE_ALIGN_CHECK_EN, LDUR at 0x3004 -> no dmem_req, wb_fault=1, wb_control[3]=0 after 1 cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the pipelined memory stage.
//   size_e     - transfer size encoding carried on ex_size
//   state_e    - memory-stage FSM states
//   CTL_*      - bit positions inside the 6-bit ex_control bundle
//   size_bytes - byte count of a transfer size
//   size_mask  - low-address mask a naturally aligned access must clear
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // ex_control = {RegWrite, MemWrite, MemRead, MemToReg, SetFlags, BL}
  localparam int CTL_BL       = 0;
  localparam int CTL_SETFLAGS = 1;
  localparam int CTL_MEMTOREG = 2;
  localparam int CTL_MEMREAD  = 3;
  localparam int CTL_MEMWRITE = 4;
  localparam int CTL_REGWRITE = 5;

  function automatic logic [3:0] size_bytes(size_e sz);
    return 4'd1 << sz;
  endfunction

  function automatic logic [2:0] size_mask(size_e sz);
    return 3'((4'd1 << sz) - 4'd1);
  endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// mem_stage_pipe_if: data-memory port of the memory stage.
//   master - memory stage: drives dmem_req/we/addr/be/wdata, receives gnt/rvalid/rdata
//   slave  - data memory: the mirror image
//
// Handshake: dmem_req is held high with dmem_we/addr/be/wdata stable until a
// cycle in which dmem_gnt is also high; that cycle is the transfer. A store is
// complete at that point. A granted load is answered by exactly one dmem_rvalid
// cycle qualifying dmem_rdata, at the earliest in the cycle after the grant.
// dmem_gnt without dmem_req, and dmem_rvalid with no load outstanding, are ignored.
interface mem_stage_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  localparam int LANES = DATA_W / 8;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [LANES-1:0]  dmem_be;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane steering, purely combinational.
//   wr_off/wr_size/wr_data -> be, wdata   : store side (byte enables, shifted data)
//   rd_off/rd_size/rd_signed/rd_data -> rd_ext : load side (extract + extend)
// Lanes past the top of the data word are simply truncated away.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]          wr_off,
  input  size_e               wr_size,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wdata,
  input  logic [2:0]          rd_off,
  input  size_e               rd_size,
  input  logic                rd_signed,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   rd_ext
);
  localparam int LANES = DATA_W / 8;
  // Wide enough to build an 8-byte mask before it is shifted and truncated.
  localparam int BEW   = LANES + 8;

  assign be    = LANES'(((BEW'(1) << size_bytes(wr_size)) - BEW'(1)) << wr_off);
  assign wdata = wr_data << {wr_off, 3'b000};

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sign_src;
  int                nbits;

  always_comb begin
    shifted  = rd_data >> {rd_off, 3'b000};
    nbits    = 8 * int'(size_bytes(rd_size));
    mask     = '1;
    sign_src = '0;
    rd_ext   = shifted;
    // A transfer as wide as the data path needs neither masking nor extension.
    if (nbits < DATA_W) begin
      mask     = ~({DATA_W{1'b1}} << nbits);
      sign_src = shifted >> (nbits - 1);
      rd_ext   = shifted & mask;
      if (rd_signed && sign_src[0]) begin
        rd_ext = rd_ext | ~mask;
      end
    end
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: registered EX/MEM -> WB stage with a req/gnt/rvalid data port.
//   clk, reset_n         - clock, asynchronous active-low reset
//   ex_*                 - instruction presented by execute
//   mem_stall            - high whenever an access is in flight (state != IDLE)
//   dmem                 - data-memory port (mem_stage_pipe_if.master)
//   wb_*                 - writeback registers; wb_valid pulses once per instruction
//   dbg_state            - current FSM state
// Optional: MEM_STAGE_ALIGN_CHECK_EN turns naturally misaligned accesses into
// a one-cycle fault (wb_fault=1, RegWrite dropped) that never reaches memory.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ex_valid,
  input  logic [ADDR_W-1:0]      ex_alu_result,
  input  logic [DATA_W-1:0]      ex_reg_data2,
  input  logic [DATA_W-1:0]      ex_bl_write_data,
  input  logic [RD_W-1:0]        ex_rd,
  input  logic [5:0]             ex_control,
  input  logic [1:0]             ex_size,
  input  logic                   ex_signed,
  input  logic [3:0]             ex_flags,
  output logic                   mem_stall,
  mem_stage_pipe_if.master       dmem,
  output logic                   wb_valid,
  output logic [DATA_W-1:0]      wb_mem_data,
  output logic [ADDR_W-1:0]      wb_alu_result,
  output logic [DATA_W-1:0]      wb_bl_write_data,
  output logic [RD_W-1:0]        wb_rd,
  output logic [3:0]             wb_control,
  output logic [3:0]             wb_flags,
  output logic                   wb_fault,
  output state_e                 dbg_state
);
  localparam int LANES = DATA_W / 8;

  state_e            state_q, state_d;
  size_e             ex_sz;
  logic              is_mem, misalign;
  logic [3:0]        wb_ctl_in;
  logic              accept_mem, done_alu, done_fault, done_store, done_load;
  logic [LANES-1:0]  be_c;
  logic [DATA_W-1:0] wdata_c, ext_c;

  // Fields held for the access in flight.
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_bl;
  logic [RD_W-1:0]   lat_rd;
  logic [3:0]        lat_wbctl, lat_flags;
  size_e             lat_size;
  logic              lat_signed;

  assign ex_sz     = size_e'(ex_size);
  assign is_mem    = ex_control[CTL_MEMWRITE] | ex_control[CTL_MEMREAD];
  assign wb_ctl_in = {ex_control[CTL_REGWRITE], ex_control[CTL_MEMTOREG],
                      ex_control[CTL_SETFLAGS], ex_control[CTL_BL]};
  assign mem_stall = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misalign = (ex_alu_result[2:0] & size_mask(ex_sz)) != 3'b000;
`else
  assign misalign = 1'b0;
`endif

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .wr_off    (ex_alu_result[2:0]),
    .wr_size   (ex_sz),
    .wr_data   (ex_reg_data2),
    .be        (be_c),
    .wdata     (wdata_c),
    .rd_off    (lat_addr[2:0]),
    .rd_size   (lat_size),
    .rd_signed (lat_signed),
    .rd_data   (dmem.dmem_rdata),
    .rd_ext    (ext_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_mem = 1'b0;
    done_alu   = 1'b0;
    done_fault = 1'b0;
    done_store = 1'b0;
    done_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!is_mem)       done_alu = 1'b1;
          else if (misalign) done_fault = 1'b1;
          else begin
            accept_mem = 1'b1;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem.dmem_gnt) begin
          if (dmem.dmem_we) begin
            done_store = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          done_load = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request side: everything is registered at acceptance so the port stays
  // stable for the whole REQ phase regardless of what EX does meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      lat_addr        <= '0;
      lat_bl          <= '0;
      lat_rd          <= '0;
      lat_wbctl       <= '0;
      lat_flags       <= '0;
      lat_size        <= SZ_B;
      lat_signed      <= 1'b0;
    end else if (accept_mem) begin
      dmem.dmem_req   <= 1'b1;
      // A store wins when both MemWrite and MemRead are set.
      dmem.dmem_we    <= ex_control[CTL_MEMWRITE];
      dmem.dmem_addr  <= {ex_alu_result[ADDR_W-1:3], 3'b000};
      dmem.dmem_be    <= be_c;
      dmem.dmem_wdata <= wdata_c;
      lat_addr        <= ex_alu_result;
      lat_bl          <= ex_bl_write_data;
      lat_rd          <= ex_rd;
      lat_wbctl       <= wb_ctl_in;
      lat_flags       <= ex_flags;
      lat_size        <= ex_sz;
      lat_signed      <= ex_signed;
    end else if (state_q == ST_REQ && dmem.dmem_gnt) begin
      dmem.dmem_req <= 1'b0;
    end
  end

  // Writeback registers: wb_valid/wb_control fall back to a bubble every
  // cycle that does not complete an instruction; the data fields hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid         <= 1'b0;
      wb_mem_data      <= '0;
      wb_alu_result    <= '0;
      wb_bl_write_data <= '0;
      wb_rd            <= '0;
      wb_control       <= '0;
      wb_flags         <= '0;
    end else begin
      wb_valid   <= 1'b0;
      wb_control <= '0;
      if (done_alu || done_fault) begin
        wb_valid         <= 1'b1;
        wb_control       <= done_fault ? {1'b0, wb_ctl_in[2:0]} : wb_ctl_in;
        wb_mem_data      <= '0;
        wb_alu_result    <= ex_alu_result;
        wb_bl_write_data <= ex_bl_write_data;
        wb_rd            <= ex_rd;
        wb_flags         <= ex_flags;
      end else if (done_store || done_load) begin
        wb_valid         <= 1'b1;
        wb_control       <= lat_wbctl;
        wb_mem_data      <= done_load ? ext_c : '0;
        wb_alu_result    <= lat_addr;
        wb_bl_write_data <= lat_bl;
        wb_rd            <= lat_rd;
        wb_flags         <= lat_flags;
      end
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              wb_fault <= 1'b0;
    else if (done_alu || done_store || done_load) wb_fault <= 1'b0;
    else if (done_fault)                       wb_fault <= 1'b1;
  end
`else
  assign wb_fault = 1'b0;
`endif

endmodule
